// File: rtl/numbotron_pkg.sv
// numbotron_pkg
// Shared definitions for the numbotron sequencer: default sizes, instruction
// field positions, opcode encoding and the instruction-pointer wrap helper.
package numbotron_pkg;

  localparam int NUM_INSN = 25;
  localparam int NUM_REGS = 8;
  localparam int IW       = 10;
  localparam int AW       = 5;   // instruction pointer / program address width
  localparam int RW       = 3;   // register select width

  localparam int OP_MSB  = 9;
  localparam int OP_LSB  = 8;
  localparam int REG_MSB = 7;
  localparam int REG_LSB = 5;
  localparam int TGT_MSB = 4;
  localparam int TGT_LSB = 0;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_INC   = 2'b01,
    OP_DECJZ = 2'b10,
    OP_HALT  = 2'b11
  } op_t;

  // Sequential successor of ip in a program of n instructions.
  function automatic logic [AW-1:0] ip_next(input logic [AW-1:0] ip, input int n);
    return (int'(ip) >= n - 1) ? '0 : ip + 1'b1;
  endfunction

endpackage

// File: rtl/numbotron_sequencer_if.sv
// numbotron_sequencer_if
// Control, program-write and status bundle of the numbotron sequencer.
//   master : driver side (run controls, program port, reg_zero flags)
//   slave  : sequencer side (strobes, ip, status flags)
interface numbotron_sequencer_if #(
  parameter int NUM_REGS = numbotron_pkg::NUM_REGS,
  parameter int IW       = numbotron_pkg::IW
);
  logic                      tick;
  logic                      step_mode;
  logic                      step_req;
  logic                      run_en;
  logic                      prog_we;
  logic [numbotron_pkg::AW-1:0] prog_addr;
  logic [IW-1:0]             prog_wdata;
  logic [NUM_REGS-1:0]       reg_zero;
  logic [NUM_REGS-1:0]       inc_regs;
  logic [NUM_REGS-1:0]       dec_regs;
  logic [numbotron_pkg::AW-1:0] ip;
  logic                      running;
  logic                      halted;
  logic                      fault;

  modport master (
    output tick, step_mode, step_req, run_en, prog_we, prog_addr, prog_wdata, reg_zero,
    input  inc_regs, dec_regs, ip, running, halted, fault
  );

  modport slave (
    input  tick, step_mode, step_req, run_en, prog_we, prog_addr, prog_wdata, reg_zero,
    output inc_regs, dec_regs, ip, running, halted, fault
  );
endinterface

// File: rtl/numbotron_progmem.sv
// numbotron_progmem
// Program store: NUM_INSN words of IW bits, synchronous write, combinational read.
// Contents are deliberately not reset so a program survives a sequencer reset.
//   clk      : system clock
//   i_we     : write enable (already qualified by the sequencer)
//   i_waddr  : write address, out-of-range writes dropped
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (0 for out-of-range addresses)
module numbotron_progmem
  import numbotron_pkg::*;
#(
  parameter int NUM_INSN = numbotron_pkg::NUM_INSN,
  parameter int IW       = numbotron_pkg::IW
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [IW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [IW-1:0] o_rdata
);

  logic [IW-1:0] r_mem [NUM_INSN];

  always_ff @(posedge clk) begin
    if (i_we && (int'(i_waddr) < NUM_INSN)) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = (int'(i_raddr) < NUM_INSN) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/numbotron_sequencer.sv
// numbotron_sequencer
// Tiny counter-machine sequencer: steps a stored program one instruction per
// advance event (tick, or step_req rising edge in single-step mode) and issues
// one-cycle increment/decrement strobes to an external register file.
//   clk  : system clock
//   rstb : asynchronous reset, active high
//   bus  : control/program/status bundle (slave side)
//
// state | meaning
// EDIT  | program may be written, ip held at 0
// IDLE  | running, waiting for an advance event
// FETCH | instruction at ip decoded, strobe/ip registered at this edge
// EXEC  | strobe and new ip visible for exactly this cycle
// HALT  | stopped by HALT or fault until run_en drops
module numbotron_sequencer
  import numbotron_pkg::*;
#(
  parameter int NUM_INSN = numbotron_pkg::NUM_INSN,
  parameter int NUM_REGS = numbotron_pkg::NUM_REGS,
  parameter int IW       = numbotron_pkg::IW
) (
  input logic              clk,
  input logic              rstb,
  numbotron_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_EDIT, S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t              r_state;
  logic [AW-1:0]       r_ip;
  op_t                 r_ir_op;
  logic [NUM_REGS-1:0] r_inc;
  logic [NUM_REGS-1:0] r_dec;
  logic                r_running;
  logic                r_halted;
  logic                r_fault;
  logic                r_step_q;

  logic                w_adv;
  logic                w_we;
  logic [IW-1:0]       w_insn;
  op_t                 w_op;
  logic [RW-1:0]       w_reg;
  logic [AW-1:0]       w_tgt;
  logic                w_tgt_bad;
  logic                w_zero;
  logic [NUM_REGS-1:0] w_onehot;

  assign w_adv = bus.step_mode ? (bus.step_req & ~r_step_q) : bus.tick;
  assign w_we  = bus.prog_we && (r_state == S_EDIT);

  numbotron_progmem #(.NUM_INSN(NUM_INSN), .IW(IW)) u_progmem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (bus.prog_addr),
    .i_wdata (bus.prog_wdata),
    .i_raddr (r_ip),
    .o_rdata (w_insn)
  );

  assign w_op      = op_t'(w_insn[OP_MSB:OP_LSB]);
  assign w_reg     = w_insn[REG_MSB:REG_LSB];
  assign w_tgt     = w_insn[TGT_MSB:TGT_LSB];
  assign w_tgt_bad = int'(w_tgt) >= NUM_INSN;
  assign w_zero    = bus.reg_zero[w_reg];
  assign w_onehot  = NUM_REGS'(1) << w_reg;

  // Decode happens at the FETCH edge so strobes are registered yet still
  // appear two cycles after the advance event.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_state   <= S_IDLE;
      r_ip      <= '0;
      r_ir_op   <= OP_NOP;
      r_inc     <= '0;
      r_dec     <= '0;
      r_running <= 1'b1;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
      r_step_q  <= 1'b0;
    end else begin
      r_step_q <= bus.step_req;
      r_inc    <= '0;
      r_dec    <= '0;
      case (r_state)
        S_EDIT: begin
          r_ip <= '0;
          if (bus.run_en) begin
            r_state   <= S_IDLE;
            r_running <= 1'b1;
            r_fault   <= 1'b0;
          end
        end
        S_IDLE: begin
          if (!bus.run_en) begin
            r_state   <= S_EDIT;
            r_ip      <= '0;
            r_running <= 1'b0;
          end else if (w_adv) begin
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_ir_op <= w_op;
          r_state <= S_EXEC;
          case (w_op)
            OP_NOP: r_ip <= ip_next(r_ip, NUM_INSN);
            OP_INC: begin
              r_inc <= w_onehot;
              r_ip  <= ip_next(r_ip, NUM_INSN);
            end
            OP_DECJZ: begin
              if (w_tgt_bad) begin
                r_fault <= 1'b1;
              end else if (w_zero) begin
                r_ip <= w_tgt;
              end else begin
                r_dec <= w_onehot;
                r_ip  <= ip_next(r_ip, NUM_INSN);
              end
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          // run_en is checked only here so a dropped run_en never cuts a strobe.
          if (!bus.run_en) begin
            r_state   <= S_EDIT;
            r_ip      <= '0;
            r_running <= 1'b0;
          end else if (r_fault || (r_ir_op == OP_HALT)) begin
            r_state   <= S_HALT;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HALT: begin
          if (!bus.run_en) begin
            r_state  <= S_EDIT;
            r_ip     <= '0;
            r_halted <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.inc_regs = r_inc;
  assign bus.dec_regs = r_dec;
  assign bus.ip       = r_ip;
  assign bus.running  = r_running;
  assign bus.halted   = r_halted;
  assign bus.fault    = r_fault;

endmodule

// File: doc/numbotron_sequencer.md
NUMBOTRON_SEQUENCER -- requirements
Module: numbotron_sequencer

Interface
REQ-001 Parameters: NUM_INSN, default 25, program length; NUM_REGS, default 8, register count; IW, default 10, instruction width.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 rstb  in  1  reset, asynchronous, active-high.
REQ-004 tick  in  1  one-cycle run-rate strobe (divided slow clock).
REQ-005 step_mode  in  1  1 = single-step; tick ignored, step_req advances.
REQ-006 step_req  in  1  step button, already debounced and synchronised, level.
REQ-007 run_en  in  1  1 = run program, 0 = edit mode.
REQ-008 prog_we / prog_addr / prog_wdata  in  1/5/IW  program write port.
REQ-009 reg_zero  in  NUM_REGS  per-register is-zero flags from the register file.
REQ-010 inc_regs / dec_regs  out  NUM_REGS  one-hot, one-cycle increment/decrement strobes.
REQ-011 ip  out  5  current instruction pointer.
REQ-012 running / halted / fault  out  1/1/1  status flags.

Function
REQ-013 Instruction word: [9:8] op, [7:5] reg, [4:0] target; op 00 NOP, 01 INC, 10 DECJZ, 11 HALT.
REQ-014 Program memory: NUM_INSN x IW, one write port, one read port; write accepted only in EDIT state, ignored otherwise; prog_addr >= NUM_INSN ignored.
REQ-015 States: EDIT, IDLE, FETCH, EXEC, HALT.
REQ-016 Advance event: tick when step_mode=0; rising edge of step_req when step_mode=1 (edge detector internal).
REQ-017 IDLE: run_en=0 -> EDIT; advance event -> FETCH; else hold.
REQ-018 FETCH: latch instruction at ip into an instruction register; -> EXEC next cycle.
REQ-019 EXEC, one cycle: NOP -> ip+1; INC -> inc_regs[reg]=1, ip+1; DECJZ with reg_zero[reg]=0 -> dec_regs[reg]=1, ip+1; DECJZ with reg_zero[reg]=1 -> no strobe, ip=target; HALT -> HALT state, ip unchanged.
REQ-020 Advance latency: event cycle N -> strobe and ip update visible in cycle N+2; at most one strobe per event.
REQ-021 ip+1 wraps from NUM_INSN-1 to 0.
REQ-022 DECJZ target >= NUM_INSN: no strobe, fault=1, -> HALT.
REQ-023 EXEC -> IDLE normally; run_en dropping during FETCH/EXEC lets the instruction complete, then -> EDIT (never aborts a strobe).
REQ-024 Advance events arriving outside IDLE are dropped, not queued.
REQ-025 EDIT: run_en=1 -> IDLE with ip=0, fault cleared; ip held at 0 in EDIT.
REQ-026 HALT: held until run_en=0 -> EDIT; advance events ignored.
REQ-027 running=1 in IDLE/FETCH/EXEC; halted=1 in HALT only; strobes 0 in all states except EXEC.

Reset
REQ-028 Reset asserted: state IDLE, ip=0, inc_regs=dec_regs=0, running=1, halted=0, fault=0, step edge detector cleared.
REQ-029 Reset mid-instruction cancels any pending strobe; program memory contents are not cleared.
REQ-030 First advance event after reset release executes instruction 0.

Structure
REQ-031 Shared package numbotron_pkg holds opcode constants, NUM_INSN, NUM_REGS, IW and field positions.
REQ-032 Program memory is a separate sub-module numbotron_progmem (sync write, combinational read).
REQ-033 State encoding lives in the sequencer only.

Verification
REQ-034 Program {0:INC r2, 1:HALT}, tick once -> inc_regs=8'h04 for exactly one cycle 2 cycles later, ip=1; second tick -> halted=1, ip=1.
REQ-035 DECJZ r1,target 7 with reg_zero[1]=0 -> dec_regs=8'h02, ip=1; with reg_zero[1]=1 -> no strobe, ip=7.
REQ-036 ip=24 executing NOP -> ip=0; DECJZ target 30 with reg zero -> fault=1, halted=1.
REQ-037 step_mode=1: ticks every cycle produce no progress; step_req held high 10 cycles -> exactly one instruction executed.
REQ-038 prog_we while running -> memory unchanged; run_en 0 in EXEC -> strobe still issued, then EDIT with ip=0.
REQ-039 rstb asserted in EXEC cycle -> strobes 0 immediately, ip=0, running=1; program preserved.
